// File: rtl/seq_detector_gen.sv
// Moore serial-pattern detector for a compile-time pattern with run-time overlap selection.
// Define SEQ_DET_MATCH_CNT_EN to add the saturating match counter and its clear input.
module seq_detector_gen #(
    parameter int unsigned        SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1010,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             A,
    input  logic             overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             Y
);

    localparam int unsigned StW = $clog2(SEQ_LEN + 1);
    localparam logic [StW-1:0] LastSt = StW'(SEQ_LEN);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
        $error("seq_detector_gen: SEQ_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_gen: CNT_W must be at least 1");
    end

    // Longest prefix of SEQ that is a suffix of (prefix_k followed by b).
    function automatic int delta_f(input int k, input int b);
        int  res;
        bit  ok;
        bit  tbit;
        int  j;
        res = 0;
        for (int l = 1; l <= int'(SEQ_LEN); l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    j    = k + 1 - l + i;
                    tbit = (j < k) ? SEQ[int'(SEQ_LEN) - 1 - j] : b[0];
                    if (SEQ[int'(SEQ_LEN) - 1 - i] != tbit) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = l;
                end
            end
        end
        return res;
    endfunction

    logic [StW-1:0] tab [SEQ_LEN+1][2];

    for (genvar k = 0; k <= SEQ_LEN; k++) begin : g_k
        for (genvar b = 0; b < 2; b++) begin : g_b
            localparam int D = delta_f(k, b);
            assign tab[k][b] = StW'(D);
        end
    end

    logic [StW-1:0] st_q, st_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (int'(st_q) > int'(SEQ_LEN)) begin
            st_d = '0;
        end else if (en) begin
            // Non-overlapping mode restarts from the empty prefix after a full match.
            if (st_q == LastSt && !overlap) begin
                st_d = tab[0][A];
            end else begin
                st_d = tab[st_q][A];
            end
        end
    end

    always_comb begin
        Y = (st_q == LastSt);
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (en && st_d == LastSt && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_gen.sv
// Bench for seq_detector_gen: three pattern configurations driven by one shared serial stream,
// checked against a sliding-window pattern model.
module tb_seq_detector_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, a = 1'b0, ovl = 1'b1, clr = 1'b0;
    logic y0, y1, y2;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [1:0] cnt0;
    logic [7:0] cnt1, cnt2;
`endif

    int checks = 0;
    int errors = 0;

    seq_detector_gen #(.SEQ_LEN(4), .SEQ(4'b1010), .CNT_W(2)) u0 (
        .clk(clk), .rst(rst), .en(en), .A(a), .overlap(ovl),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr(clr), .match_cnt(cnt0),
`endif
        .Y(y0)
    );

    seq_detector_gen #(.SEQ_LEN(3), .SEQ(3'b111), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .A(a), .overlap(ovl),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr(clr), .match_cnt(cnt1),
`endif
        .Y(y1)
    );

    seq_detector_gen #(.SEQ_LEN(5), .SEQ(5'b11011), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .A(a), .overlap(ovl),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr(clr), .match_cnt(cnt2),
`endif
        .Y(y2)
    );

    // Reference model: a match is the last L enabled bits equal to the pattern, all received
    // since reset or since the last non-overlapping cut.
    int          plen [3] = '{4, 3, 5};
    logic [31:0] ppat [3] = '{32'b1010, 32'b111, 32'b11011};
    logic [31:0] hist [3];
    int          avail[3];
    logic        my   [3];
    int          mcnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic o,
                        input logic c);
        logic [31:0] mask;
        rst = r; en = e; a = b; ovl = o; clr = c;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            mask = (32'd1 << plen[d]) - 32'd1;
            if (r) begin
                hist[d] = '0; avail[d] = 0; my[d] = 1'b0;
            end else if (e) begin
                if (my[d] && !o) avail[d] = 0;
                hist[d] = {hist[d][30:0], b};
                if (avail[d] < 32) avail[d]++;
                my[d] = (avail[d] >= plen[d]) && ((hist[d] & mask) == ppat[d]);
            end
        end
        if (r) mcnt = 0;
        else if (c) mcnt = 0;
        else if (e && my[0] && mcnt < 3) mcnt++;
        #1;
        check("model_y0", {15'd0, y0}, {15'd0, my[0]});
        check("model_y1", {15'd0, y1}, {15'd0, my[1]});
        check("model_y2", {15'd0, y2}, {15'd0, my[2]});
`ifdef SEQ_DET_MATCH_CNT_EN
        check("model_cnt0", {14'd0, cnt0}, 16'(mcnt));
`endif
    endtask

    // Feed n bits MSB first with en=1 and compare one DUT's Y against a literal expectation.
    task automatic run(input logic [15:0] bits, input logic [15:0] exp, input int n,
                       input int d, input logic o, input string tag);
        logic obs;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], o, 1'b0);
            obs = (d == 0) ? y0 : ((d == 1) ? y1 : y2);
            check(tag, {15'd0, obs}, {15'd0, exp[i]});
        end
    endtask

    initial begin
        logic o;
        mcnt = 0;
        for (int d = 0; d < 3; d++) begin
            hist[d] = '0; avail[d] = 0; my[d] = 1'b0;
        end

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_y0", {15'd0, y0}, 16'd0);
        check("rst_y1", {15'd0, y1}, 16'd0);

        // T1 overlap on 1010
        run(16'b101010, 16'b000101, 6, 0, 1'b1, "t1");
        // T2 non-overlap on 1010
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(16'b10101010, 16'b00010001, 8, 0, 1'b0, "t2");
        // T3 pattern 111 with full-length border
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(16'b11111, 16'b00111, 5, 1, 1'b1, "t3_ovl");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(16'b11111, 16'b00100, 5, 1, 1'b0, "t3_novl");
        // T4 enable gap mid-pattern, then hold of Y while disabled
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(16'b101, 16'b000, 3, 0, 1'b1, "t4_pre");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("t4_gap", {15'd0, y0}, 16'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_match", {15'd0, y0}, 16'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("t4_hold", {15'd0, y0}, 16'd1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_drop", {15'd0, y0}, 16'd0);
        // T5 reset discards a partial match
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(16'b101, 16'b000, 3, 0, 1'b1, "t5_pre");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_rst", {15'd0, y0}, 16'd0);
        run(16'b01010, 16'b00001, 5, 0, 1'b1, "t5_post");

`ifdef SEQ_DET_MATCH_CNT_EN
        // T6 saturating counter and clear priority
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 10; r++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check("t6_cnt", {14'd0, cnt0}, 16'((r - 1 > 3) ? 3 : r - 1));
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t6_clr_y", {15'd0, y0}, 16'd1);
        check("t6_clr_cnt", {14'd0, cnt0}, 16'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_after_clr", {14'd0, cnt0}, 16'd1);
`endif

        // Randomized stream with occasional reset, enable gaps, overlap flips and clears
        o = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) o = ~o;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), o, ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
